maxpool_window_sequencer: RTL and testbench

- Sequences one max-pooling pass over a stream of systolic-array output rows.
- Folds each group of filter_size consecutive rows into an element-wise signed running max (pooling window height, stride = window).
- Emits one pooled row per window together with vmax_sel, which picks the matching horizontal-pooling result (VMaxs[vmax_sel]) in the downstream combinational max calculator.
- Sits between the array drain logic and the pooling datapath; owns all max-pool control state.

---
 rtl/maxpool_window_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_maxpool_window_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_window_sequencer.sv
// Max-pool window sequencer.
// Folds each group of filter_size consecutive array rows into an element-wise
// signed running max. Each completed window is presented on out_row together with
// vmax_sel, which selects the matching horizontal-pooling result downstream.
// The trailing partial window of a pass is emitted as the max of the rows it received.
module maxpool_window_sequencer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SA_LENGTH       = 256,
  parameter int unsigned MAX_FILTER_SIZE = 7,
  parameter int unsigned ROW_CNT_WIDTH   = 16,
  localparam int unsigned FsWidth        = $clog2(MAX_FILTER_SIZE + 1),
  localparam int unsigned SelWidth       = (MAX_FILTER_SIZE > 1) ? $clog2(MAX_FILTER_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [FsWidth-1:0]           filter_size,
  input  logic [ROW_CNT_WIDTH-1:0]     in_rows,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_row [SA_LENGTH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_row [SA_LENGTH],
  output logic [SelWidth-1:0]          vmax_sel,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_error
);

  localparam logic [FsWidth-1:0]       FsMax  = FsWidth'(MAX_FILTER_SIZE);
  localparam logic [FsWidth-1:0]       FsOne  = FsWidth'(1);
  localparam logic [ROW_CNT_WIDTH-1:0] RowOne = ROW_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StEmit,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Latched pass configuration
  logic [FsWidth-1:0]       fs_q;
  logic [ROW_CNT_WIDTH-1:0] rows_q;
  logic [SelWidth-1:0]      vmax_sel_q;

  // Position within the current window and within the whole pass
  logic [FsWidth-1:0]       win_cnt_q;
  logic [ROW_CNT_WIDTH-1:0] row_cnt_q;

  logic                         cfg_error_q;
  logic signed [DATA_WIDTH-1:0] acc_q [SA_LENGTH];

  logic cfg_legal;
  logic start_idle;
  logic start_run;
  logic start_zero;
  logic start_bad;
  logic in_fire;
  logic out_fire;
  logic win_last;
  logic row_last;
  logic rows_done;

  assign cfg_legal  = (filter_size != '0) && (filter_size <= FsMax);
  assign start_idle = (state_q == StIdle) && start;
  assign start_run  = start_idle && cfg_legal && (in_rows != '0);
  assign start_zero = start_idle && cfg_legal && (in_rows == '0);
  assign start_bad  = start_idle && !cfg_legal;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign win_last  = (win_cnt_q == (fs_q - FsOne));
  assign row_last  = (row_cnt_q == (rows_q - RowOne));
  assign rows_done = (row_cnt_q == rows_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_run) begin
          state_d = StAccum;
        end else if (start_zero) begin
          state_d = StDone;
        end
      end
      StAccum: begin
        if (in_fire && (win_last || row_last)) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_fire) begin
          state_d = rows_done ? StDone : StAccum;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle:  busy      = 1'b0;
      StAccum: in_ready  = 1'b1;
      StEmit:  out_valid = 1'b1;
      StDone:  done      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Configuration latch and window/pass counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q       <= '0;
      rows_q     <= '0;
      vmax_sel_q <= '0;
      win_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else if (start_run) begin
      fs_q       <= filter_size;
      rows_q     <= in_rows;
      vmax_sel_q <= SelWidth'(filter_size - FsOne);
      win_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else if (in_fire) begin
      win_cnt_q <= win_cnt_q + FsOne;
      row_cnt_q <= row_cnt_q + RowOne;
    end else if (out_fire) begin
      win_cnt_q <= '0;
    end
  end

  // One-cycle error pulse for an out-of-range window size; config stays untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_error_q <= 1'b0;
    end else begin
      cfg_error_q <= start_bad;
    end
  end

  // Running max; the first row of a window loads directly so all-negative windows work
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < SA_LENGTH; j++) begin
        acc_q[j] <= '0;
      end
    end else if (in_fire) begin
      for (int j = 0; j < SA_LENGTH; j++) begin
        if ((win_cnt_q == '0) || (in_row[j] > acc_q[j])) begin
          acc_q[j] <= in_row[j];
        end
      end
    end
  end

  assign out_row   = acc_q;
  assign vmax_sel  = vmax_sel_q;
  assign cfg_error = cfg_error_q;

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Self-checking bench for maxpool_window_sequencer: expected pooled rows are pushed to a
// queue as input rows are driven and popped when the DUT hands a row downstream.
module tb_maxpool_window_sequencer;

  localparam int DW   = 32;
  localparam int SL   = 4;
  localparam int MF   = 5;
  localparam int RCW  = 16;
  localparam int FSW  = $clog2(MF + 1);
  localparam int SELW = $clog2(MF);
  localparam int ROWW = DW * SL;

  typedef logic [ROWW-1:0] rowv_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [FSW-1:0]       filter_size = '0;
  logic [RCW-1:0]       in_rows = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_row [SL];
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_row [SL];
  logic [SELW-1:0]      vmax_sel;
  logic                 busy;
  logic                 done;
  logic                 cfg_error;

  always #5 clk = ~clk;

  maxpool_window_sequencer #(
    .DATA_WIDTH     (DW),
    .SA_LENGTH      (SL),
    .MAX_FILTER_SIZE(MF),
    .ROW_CNT_WIDTH  (RCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .filter_size(filter_size),
    .in_rows    (in_rows),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .vmax_sel   (vmax_sel),
    .busy       (busy),
    .done       (done),
    .cfg_error  (cfg_error)
  );

  int              n_tests = 0;
  int              n_fail = 0;
  rowv_t           exp_q[$];
  logic [SELW-1:0] exp_sel = '0;
  int              done_cnt = 0;
  int              out_cnt = 0;
  int              log_n = 0;
  logic [31:0]     ir_log = '0;
  int              vals[$];

  task automatic check_eq(input string tag, input rowv_t got, input rowv_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rowv_t out_vec();
    rowv_t v;
    for (int j = 0; j < SL; j++) v[j*DW +: DW] = out_row[j];
    return v;
  endfunction

  task automatic set_in(input rowv_t r);
    for (int j = 0; j < SL; j++) in_row[j] = r[j*DW +: DW];
  endtask

  // Monitor: count done pulses, log in_ready while busy, score every output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (busy && log_n < 32) begin
        ir_log[log_n] = in_ready;
        log_n++;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", rowv_t'(exp_q.size()), rowv_t'(1));
        end else begin
          check_eq("out_row", out_vec(), exp_q.pop_front());
          check_eq("vmax_sel", rowv_t'(vmax_sel), rowv_t'(exp_sel));
        end
      end
    end
  end

  task automatic do_start(input int fs, input int nrows);
    filter_size = FSW'(fs);
    in_rows     = RCW'(nrows);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_row(input rowv_t r);
    int n = 0;
    in_valid = 1'b1;
    set_in(r);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", rowv_t'(in_ready), rowv_t'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_pass(input int fs, input int nrows, input bit neg, input int hold);
    rowv_t row;
    rowv_t acc;
    int    e;
    int    n;
    int    d0 = done_cnt;
    int    o0 = out_cnt;
    exp_sel = SELW'(fs - 1);
    do_start(fs, nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int j = 0; j < SL; j++) begin
        if (neg) e = vals[r] - j;
        else if (j == 0 && r < vals.size()) e = vals[r];
        else e = int'($urandom());
        row[j*DW +: DW] = e;
      end
      if (r % fs == 0) begin
        acc = row;
      end else begin
        for (int j = 0; j < SL; j++)
          if ($signed(row[j*DW +: DW]) > $signed(acc[j*DW +: DW])) acc[j*DW +: DW] = row[j*DW +: DW];
      end
      if ((r % fs == fs - 1) || (r == nrows - 1)) exp_q.push_back(acc);
      if (hold > 0 && r == fs - 1) out_ready = 1'b0;
      drive_row(row);
      if (hold > 0 && r == fs - 1) begin
        // Offer a junk row during the stall; it must not be taken
        in_valid = 1'b1;
        set_in(~row);
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          check_eq("hold_valid", rowv_t'(out_valid), rowv_t'(1));
          check_eq("hold_in_ready", rowv_t'(in_ready), rowv_t'(0));
          check_eq("hold_row", out_vec(), acc);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
    end
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("pass_end_busy", rowv_t'(busy), rowv_t'(0));
    check_eq("done_pulses", rowv_t'(done_cnt - d0), rowv_t'(1));
    check_eq("out_count", rowv_t'(out_cnt - o0), rowv_t'((nrows + fs - 1) / fs));
    check_eq("queue_drained", rowv_t'(exp_q.size()), rowv_t'(0));
    @(posedge clk); #1;
  endtask

  task automatic bad_start(input int fs, input string tag);
    do_start(fs, 4);
    @(negedge clk);
    check_eq({tag, "_err"}, rowv_t'({cfg_error, busy}), rowv_t'(2'b10));
    @(negedge clk);
    check_eq({tag, "_err_clr"}, rowv_t'({cfg_error, busy}), rowv_t'(2'b00));
    check_eq({tag, "_sel_kept"}, rowv_t'(vmax_sel), rowv_t'(exp_sel));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    d0;
    int    o0;
    rowv_t row;
    set_in('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctl", rowv_t'({busy, in_ready, out_valid, done, cfg_error, vmax_sel}),
             rowv_t'(0));
    check_eq("reset_row", out_vec(), rowv_t'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    vals = '{3, -1, 7, 5};
    run_pass(2, 4, 1'b0, 0);

    bad_start(0, "fs0");
    bad_start(6, "fs6");

    d0 = done_cnt;
    o0 = out_cnt;
    do_start(2, 0);
    repeat (4) @(negedge clk);
    check_eq("zero_rows_done", rowv_t'(done_cnt - d0), rowv_t'(1));
    check_eq("zero_rows_no_out", rowv_t'(out_cnt - o0), rowv_t'(0));
    check_eq("zero_rows_busy", rowv_t'(busy), rowv_t'(0));
    @(posedge clk); #1;

    vals = '{-9, -4, -6, -2, -8, -3, -5};
    run_pass(3, 7, 1'b1, 0);

    vals.delete();
    log_n  = 0;
    ir_log = '0;
    run_pass(1, 3, 1'b0, 0);
    check_eq("fs1_in_ready_seq", rowv_t'(ir_log[6:0]), rowv_t'(7'b0010101));

    run_pass(2, 4, 1'b0, 5);

    // Abort a pass after one row and confirm a clean return to reset values
    exp_sel = SELW'(2);
    do_start(3, 3);
    row = {$urandom(), $urandom(), $urandom(), $urandom()};
    drive_row(row);
    d0  = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_ctl", rowv_t'({busy, in_ready, out_valid, done, cfg_error, vmax_sel}),
             rowv_t'(0));
    check_eq("abort_row", out_vec(), rowv_t'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_no_done", rowv_t'(done_cnt - d0), rowv_t'(0));

    run_pass(3, 5, 1'b0, 0);
    run_pass(MF, 11, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
